// File: rtl/alu_mdu_sequencer_if.sv
// Execute-stage bundle between the pipeline/ALU and the iterative multiply/divide sequencer.
// master = pipeline and shared ALU side, slave = sequencer.
interface alu_mdu_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] src_a;
   logic [DATA_WIDTH-1:0] src_b;
   logic                  kill;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_own;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [2:0]            alu_ctrl;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] result;

   modport master (
      output start, op, src_a, src_b, kill, alu_result,
      input  alu_own, alu_a, alu_b, alu_ctrl, busy, done, result
   );

   modport slave (
      input  start, op, src_a, src_b, kill, alu_result,
      output alu_own, alu_a, alu_b, alu_ctrl, busy, done, result
   );
endinterface

// File: rtl/alu_mdu_sequencer.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the shared ALU (add 3'b000, sub 3'b001).
// Optional macro MDU_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module alu_mdu_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   alu_mdu_sequencer_if.slave bus
);
   localparam int         CW       = $clog2(DATA_WIDTH) + 1;
   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_RSVD  = 2'b11;
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d;
   // acc = product accumulator / remainder, opnd = multiplicand / divisor, shf = multiplier / quotient
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
   logic [DATA_WIDTH-1:0] shf_q, shf_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH:0]   rem_sh_s;
   logic                  last_s;

   assign rem_sh_s = {acc_q, shf_q[DATA_WIDTH-1]};

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      shf_d    = shf_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      last_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.kill) begin
               state_d = S_IDLE;
            end else if (bus.start) begin
               op_d   = bus.op;
               acc_d  = {DATA_WIDTH{1'b0}};
               opnd_d = (bus.op == OP_MUL) ? bus.src_a : bus.src_b;
               shf_d  = (bus.op == OP_MUL) ? bus.src_b : bus.src_a;
               cnt_d  = {CW{1'b0}};
               if (bus.op == OP_RSVD) begin
                  state_d  = S_DONE;
                  result_d = {DATA_WIDTH{1'b0}};
               end else if ((bus.op != OP_MUL) && (bus.src_b == {DATA_WIDTH{1'b0}})) begin
                  state_d  = S_DONE;
                  result_d = (bus.op == OP_DIVU) ? {DATA_WIDTH{1'b1}} : bus.src_a;
`ifdef MDU_EARLY_OUT_EN
               end else if ((bus.op == OP_MUL) && (bus.src_b == {DATA_WIDTH{1'b0}})) begin
                  state_d  = S_DONE;
                  result_d = {DATA_WIDTH{1'b0}};
`endif
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (bus.kill) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (op_q == OP_MUL) begin
                  acc_d  = shf_q[0] ? bus.alu_result : acc_q;
                  opnd_d = opnd_q << 1;
                  shf_d  = shf_q >> 1;
               end else if (rem_sh_s[DATA_WIDTH] || (rem_sh_s[DATA_WIDTH-1:0] >= opnd_q)) begin
                  acc_d = bus.alu_result;
                  shf_d = {shf_q[DATA_WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = rem_sh_s[DATA_WIDTH-1:0];
                  shf_d = {shf_q[DATA_WIDTH-2:0], 1'b0};
               end
               last_s = (cnt_q == CW'(DATA_WIDTH - 1));
`ifdef MDU_EARLY_OUT_EN
               if ((op_q == OP_MUL) && (shf_d == {DATA_WIDTH{1'b0}})) begin
                  last_s = 1'b1;
               end else begin
                  last_s = last_s;
               end
`endif
               if (last_s) begin
                  state_d  = S_DONE;
                  result_d = (op_q == OP_DIVU) ? shf_d : acc_d;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ALU operand mux drive, active only while iterating
   always_comb begin
      bus.alu_own  = 1'b0;
      bus.alu_a    = {DATA_WIDTH{1'b0}};
      bus.alu_b    = {DATA_WIDTH{1'b0}};
      bus.alu_ctrl = ALU_ADD;
      if (state_q == S_RUN) begin
         bus.alu_own = 1'b1;
         bus.alu_b   = opnd_q;
         if (op_q == OP_MUL) begin
            bus.alu_a    = acc_q;
            bus.alu_ctrl = ALU_ADD;
         end else begin
            bus.alu_a    = rem_sh_s[DATA_WIDTH-1:0];
            bus.alu_ctrl = ALU_SUB;
         end
      end else begin
         bus.alu_own  = 1'b0;
         bus.alu_ctrl = ALU_ADD;
      end
   end

   assign bus.busy   = (state_q == S_RUN);
   assign bus.done   = (state_q == S_DONE) && !bus.kill;
   assign bus.result = result_q;

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MUL;
         acc_q    <= {DATA_WIDTH{1'b0}};
         opnd_q   <= {DATA_WIDTH{1'b0}};
         shf_q    <= {DATA_WIDTH{1'b0}};
         result_q <= {DATA_WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         shf_q    <= shf_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule
